acc_collector: RTL and testbench

Downstream stage of the systolic-array controller. Captures the per-column partial-sum outputs from the bottom PE row whenever the matching `acc_valid_i[j]` is high, and removes the one-cycle-per-column skew so that complete result rows can be reassembled. Buffers the rows and streams them out over a valid/ready handshake. Also counts emitted rows and signals when a full N-row result matrix has drained.

---
 rtl/acc_collector_if.sv | 30 +++
 rtl/acc_collector.sv | 167 ++++++++++++++++
 tb/tb_acc_collector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_collector_if
// Brief    : Capture strobes/partial sums in, result-row stream out.
// Revision : 1.0
// ============================================================================
interface acc_collector_if #(
   parameter int N      = 4,
   parameter int PSUM_W = 32
);
   logic [N-1:0]        acc_valid_i;
   logic [N*PSUM_W-1:0] psum_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [N*PSUM_W-1:0] out_data_o;
   logic                done_o;
   logic                overflow_o;

   // master: the collector itself, which sources the result stream
   modport master (
      input  acc_valid_i, psum_i, out_ready_i,
      output out_valid_o, out_data_o, done_o, overflow_o
   );

   modport slave (
      output acc_valid_i, psum_i, out_ready_i,
      input  out_valid_o, out_data_o, done_o, overflow_o
   );
endinterface
`default_nettype wire

// File: rtl/acc_collector.sv
`default_nettype none
// ============================================================================
// Module   : acc_collector
// Brief    : De-skews bottom-row partial sums into rows, buffers them and
//            streams them out; optional ReLU clamp via ACC_COLLECT_RELU_EN.
// Revision : 1.0
// ============================================================================
module acc_collector #(
   parameter int N      = 4,
   parameter int PSUM_W = 32,
   parameter int DEPTH  = 8
) (
   input wire              clk_i,
   input wire              rst_i,
   input wire              clear_i,
   acc_collector_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(N) + 1;
   localparam int DW = N * PSUM_W;
   localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
   localparam logic [PW-1:0] C_NROWS = PW'(N);
   localparam logic [CW-1:0] C_LAST  = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2
   } state_e;

   logic [PW-1:0]     wr_ptr_q [N];
   logic [PW-1:0]     wr_ptr_d [N];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     row_cnt_q, row_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;
   state_e            state_q, state_d;

   logic [PSUM_W-1:0] mem_q [DEPTH][N];

   logic [N-1:0]      col_full;
   logic [N-1:0]      wr_en;
   logic [DW-1:0]     rd_row;
   logic              row_ready;
   logic              xfer;
   logic              load;
   logic              drain_hit;

   for (genvar j = 0; j < N; j++) begin : g_col
      logic [PW-1:0]     fill;
      logic [PSUM_W-1:0] rd_val;

      assign fill        = wr_ptr_q[j] - rd_ptr_q;
      assign col_full[j] = (fill == C_DEPTH);
      assign wr_en[j]    = bus.acc_valid_i[j] && !col_full[j] && !clear_i;
      assign rd_val      = mem_q[rd_ptr_q[AW-1:0]][j];
`ifdef ACC_COLLECT_RELU_EN
      assign rd_row[j*PSUM_W +: PSUM_W] = rd_val[PSUM_W-1] ? '0 : rd_val;
`else
      assign rd_row[j*PSUM_W +: PSUM_W] = rd_val;
`endif
   end

   // Buffer storage carries no reset: validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < N; j++) begin
         if (wr_en[j]) begin
            mem_q[wr_ptr_q[j][AW-1:0]][j] <= bus.psum_i[j*PSUM_W +: PSUM_W];
         end
      end
   end

   // Column N-1 arrives last, so its pointer alone decides row completeness.
   assign row_ready = (wr_ptr_q[N-1] != rd_ptr_q);
   assign xfer      = out_valid_q && bus.out_ready_i;
   assign load      = row_ready && (!out_valid_q || bus.out_ready_i);
   assign drain_hit = ((wr_ptr_q[N-1] - PW'(row_cnt_q)) == C_NROWS);

   always_comb begin
      for (int j = 0; j < N; j++) begin
         wr_ptr_d[j] = clear_i ? '0 : (wr_ptr_q[j] + PW'(wr_en[j]));
      end
   end

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      row_cnt_d   = row_cnt_q;
      done_d      = 1'b0;
      overflow_d  = overflow_q | (|(bus.acc_valid_i & col_full));

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_row;
         rd_ptr_d    = rd_ptr_q + 1'b1;
      end else if (xfer) begin
         out_valid_d = 1'b0;
      end

      if (xfer) begin
         if (row_cnt_q == C_LAST) begin
            row_cnt_d = '0;
            done_d    = 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end

      if (clear_i) begin
         rd_ptr_d    = '0;
         out_valid_d = 1'b0;
         row_cnt_d   = '0;
         done_d      = 1'b0;
         overflow_d  = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (|bus.acc_valid_i) state_d = S_COLLECT;
         S_COLLECT: if (drain_hit)         state_d = S_DRAIN;
         S_DRAIN:   if (done_d)            state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
      if (clear_i) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int j = 0; j < N; j++) begin
            wr_ptr_q[j] <= '0;
         end
         rd_ptr_q    <= '0;
         row_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         state_q     <= S_IDLE;
      end else begin
         for (int j = 0; j < N; j++) begin
            wr_ptr_q[j] <= wr_ptr_d[j];
         end
         rd_ptr_q    <= rd_ptr_d;
         row_cnt_q   <= row_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.done_o      = done_q;
   assign bus.overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_acc_collector
// Brief    : Directed self-checking bench for acc_collector.
// Revision : 1.0
// ============================================================================
module tb_acc_collector;
   localparam int N      = 4;
   localparam int PSUM_W = 32;
   localparam int DEPTH  = 8;
   localparam int DW     = N * PSUM_W;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   acc_collector_if #(.N(N), .PSUM_W(PSUM_W)) bus ();

   acc_collector #(.N(N), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int exp_row  = 0;
   int done_cnt = 0;

   logic [N-1:0]  av;
   logic [DW-1:0] ps;
   logic [DW-1:0] relu_exp;
   int            start_t [20];
   int            next_r;
   logic          rdy;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] row_of(input int r);
      logic [DW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++) v[j*PSUM_W +: PSUM_W] = PSUM_W'(16 * r + j);
      return v;
   endfunction

   // Column j carries row r on cycle t = r + j.
   task automatic skew(input int t, input int nrows, output logic [N-1:0] a, output logic [DW-1:0] p);
      a = '0;
      p = '0;
      for (int j = 0; j < N; j++) begin
         if ((t - j) >= 0 && (t - j) < nrows) begin
            a[j] = 1'b1;
            p[j*PSUM_W +: PSUM_W] = PSUM_W'(16 * (t - j) + j);
         end
      end
   endtask

   // Drives one cycle and scores any transfer or stall on that edge.
   task automatic step(input logic [N-1:0] a, input logic [DW-1:0] p, input logic r);
      logic          pv;
      logic [DW-1:0] pd;
      bus.acc_valid_i = a;
      bus.psum_i      = p;
      bus.out_ready_i = r;
      pv = bus.out_valid_o;
      pd = bus.out_data_o;
      tick();
      if (pv && r) begin
         check($sformatf("row_%0d", exp_row), pd, row_of(exp_row));
         exp_row++;
      end else if (pv) begin
         check_bit("hold_valid", bus.out_valid_o, 1'b1);
         check("hold_data", bus.out_data_o, pd);
      end
      if (bus.done_o) done_cnt++;
   endtask

   task automatic do_clear();
      bus.acc_valid_i = '0;
      bus.psum_i      = '0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      bus.acc_valid_i = '0;
      bus.psum_i      = '0;
      bus.out_ready_i = 1'b0;
      #12 rst = 1'b0;
      tick();
      check_bit("rst_valid", bus.out_valid_o, 1'b0);
      check("rst_data", bus.out_data_o, '0);
      check_bit("rst_done", bus.done_o, 1'b0);
      check_bit("rst_ovf", bus.overflow_o, 1'b0);
      check("rst_state", DW'(dut.state_q), '0);

      // Skewed fill, consumer always ready: exact cycle timing.
      bus.out_ready_i = 1'b1;
      for (int t = 0; t < 12; t++) begin
         skew(t, 4, av, ps);
         bus.acc_valid_i = av;
         bus.psum_i      = ps;
         tick();
         check_bit($sformatf("skew_valid_%0d", t), bus.out_valid_o, (t >= 4 && t <= 7));
         if (t >= 4 && t <= 7) check($sformatf("skew_data_%0d", t), bus.out_data_o, row_of(t - 4));
         check_bit($sformatf("skew_done_%0d", t), bus.done_o, (t == 8));
      end
      do_clear();

      // Backpressure: ready low for the first 6 cycles.
      exp_row  = 0;
      done_cnt = 0;
      for (int t = 0; t < 16; t++) begin
         skew(t, 4, av, ps);
         step(av, ps, (t >= 6));
      end
      check("bp_rows", DW'(exp_row), DW'(4));
      check("bp_done", DW'(done_cnt), DW'(1));
      check_bit("bp_ovf", bus.overflow_o, 1'b0);
      do_clear();

      // Overflow: column 0 only, nothing drains.
      bus.out_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.acc_valid_i = 4'b0001;
         bus.psum_i      = DW'(i);
         tick();
         if (i == 7) check_bit("ovf_before", bus.overflow_o, 1'b0);
      end
      check_bit("ovf_after", bus.overflow_o, 1'b1);
      check("ovf_wrptr0", DW'(dut.wr_ptr_q[0]), DW'(8));
      check_bit("ovf_novalid", bus.out_valid_o, 1'b0);
      do_clear();
      check_bit("ovf_clr", bus.overflow_o, 1'b0);

      // Clear with a coincident strobe after two captured rows.
      for (int t = 0; t < 5; t++) begin
         skew(t, 2, av, ps);
         bus.acc_valid_i = av;
         bus.psum_i      = ps;
         tick();
      end
      check_bit("clr_pre_valid", bus.out_valid_o, 1'b1);
      check("clr_pre_data", bus.out_data_o, row_of(0));
      bus.acc_valid_i = 4'b1111;
      bus.psum_i      = row_of(9);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bus.acc_valid_i = '0;
      check_bit("clr_valid", bus.out_valid_o, 1'b0);
      check("clr_state", DW'(dut.state_q), '0);
      check("clr_wrptr0", DW'(dut.wr_ptr_q[0]), '0);
      check("clr_wrptr3", DW'(dut.wr_ptr_q[3]), '0);
      tick();
      check_bit("clr_still_empty", bus.out_valid_o, 1'b0);

      // Asynchronous reset mid-matrix.
      for (int t = 0; t < 5; t++) begin
         skew(t, 2, av, ps);
         bus.acc_valid_i = av;
         bus.psum_i      = ps;
         tick();
      end
      bus.acc_valid_i = '0;
      check_bit("arst_pre_valid", bus.out_valid_o, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_bit("arst_valid", bus.out_valid_o, 1'b0);
      check("arst_data", bus.out_data_o, '0);
      check("arst_wrptr3", DW'(dut.wr_ptr_q[3]), '0);
      #2 rst = 1'b0;
      tick();
      check_bit("arst_done", bus.done_o, 1'b0);
      check_bit("arst_after", bus.out_valid_o, 1'b0);

      // ReLU row {-5, 7, -1, 0}.
      bus.out_ready_i = 1'b1;
`ifdef ACC_COLLECT_RELU_EN
      relu_exp = {32'h0, 32'h0, 32'h7, 32'h0};
`else
      relu_exp = {32'h0, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFB};
`endif
      for (int t = 0; t < 6; t++) begin
         av = '0;
         ps = {32'h0, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFB};
         if (t < 4) av[t] = 1'b1;
         bus.acc_valid_i = av;
         bus.psum_i      = ps;
         tick();
         if (t == 4) begin
            check_bit("relu_valid", bus.out_valid_o, 1'b1);
            check("relu_data", bus.out_data_o, relu_exp);
         end
      end
      do_clear();

      // Wrap-around: 20 rows, random ready, producer paced by delivered rows.
      exp_row  = 0;
      done_cnt = 0;
      next_r   = 0;
      for (int r = 0; r < 20; r++) start_t[r] = -100;
      for (int t = 0; t < 400 && exp_row < 20; t++) begin
         if (next_r < 20 && (next_r - exp_row) < 6) begin
            start_t[next_r] = t;
            next_r++;
         end
         av = '0;
         ps = '0;
         for (int j = 0; j < N; j++) begin
            for (int r = 0; r < next_r; r++) begin
               if (start_t[r] + j == t) begin
                  av[j] = 1'b1;
                  ps[j*PSUM_W +: PSUM_W] = PSUM_W'(16 * r + j);
               end
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         step(av, ps, rdy);
      end
      check("wrap_rows", DW'(exp_row), DW'(20));
      check("wrap_done", DW'(done_cnt), DW'(5));
      check_bit("wrap_ovf", bus.overflow_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
